// File: rtl/uart_pkg.sv
// Constants shared by the APB register block and the UART transmit FIFO.
package uart_pkg;
    localparam int UART_DATA_WIDTH  = 16;
    localparam int TX_FIFO_DEPTH    = 16;
    localparam int TX_FIFO_AW       = 4;
    localparam int TX_FIFO_AF_LEVEL = 14;
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered synchronous read.
import uart_pkg::*;

module fifo_mem #(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int ADDR_WIDTH = TX_FIFO_AW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Only the output register is reset; array contents survive reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO: wrap-bit pointers, registered status flags, sticky overflow.
import uart_pkg::*;

module uart_tx_fifo #(
    parameter int DATA_WIDTH = UART_DATA_WIDTH,
    parameter int DEPTH      = TX_FIFO_DEPTH,
    parameter int ADDR_WIDTH = TX_FIFO_AW,
    parameter int AF_LEVEL   = TX_FIFO_AF_LEVEL
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  rd_en,
    input  logic                  ovf_clr,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   data_count,
    output logic                  overflow
);
    localparam logic [ADDR_WIDTH:0] AF_THRESH = AF_LEVEL[ADDR_WIDTH:0];

    logic [ADDR_WIDTH:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_WIDTH:0] count_reg, count_next;
    logic                full_reg, full_next;
    logic                empty_reg, empty_next;
    logic                af_reg, af_next;
    logic                ovf_reg, ovf_next;
    logic                push, pop;

    // Acceptance uses only registered flags, so there is no write-through or fall-through.
    assign push = wr_en && !full_reg;
    assign pop  = rd_en && !empty_reg;

    always_comb begin
        wr_ptr_next = wr_ptr_reg + {{ADDR_WIDTH{1'b0}}, push};
        rd_ptr_next = rd_ptr_reg + {{ADDR_WIDTH{1'b0}}, pop};
        count_next  = wr_ptr_next - rd_ptr_next;
        empty_next  = (wr_ptr_next == rd_ptr_next);
        full_next   = (wr_ptr_next[ADDR_WIDTH] != rd_ptr_next[ADDR_WIDTH]) &&
                      (wr_ptr_next[ADDR_WIDTH-1:0] == rd_ptr_next[ADDR_WIDTH-1:0]);
        af_next     = (count_next >= AF_THRESH);
        ovf_next    = ovf_reg;
        if (ovf_clr) begin
            ovf_next = 1'b0;
        end
        if (wr_en && full_reg) begin
            ovf_next = 1'b1;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
            af_reg     <= 1'b0;
            ovf_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            full_reg   <= full_next;
            empty_reg  <= empty_next;
            af_reg     <= af_next;
            ovf_reg    <= ovf_next;
        end
    end

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk  (PCLK),
        .rst  (PRESET),
        .we   (push),
        .waddr(wr_ptr_reg[ADDR_WIDTH-1:0]),
        .wdata(din),
        .re   (pop),
        .raddr(rd_ptr_reg[ADDR_WIDTH-1:0]),
        .rdata(dout)
    );

    assign full        = full_reg;
    assign empty       = empty_reg;
    assign almost_full = af_reg;
    assign data_count  = count_reg;
    assign overflow    = ovf_reg;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model checked every cycle plus directed literal checks.
module tb_uart_tx_fifo;
    localparam int DW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AFL   = 14;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic          wr_en, rd_en, ovf_clr;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
    logic          full, empty, almost_full, overflow;
    logic [AW:0]   data_count;

    int checks = 0;
    int errors = 0;
    bit run_cmp = 1'b0;

    uart_tx_fifo #(
        .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_LEVEL(AFL)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .wr_en(wr_en), .din(din), .rd_en(rd_en),
        .ovf_clr(ovf_clr), .dout(dout), .full(full), .empty(empty),
        .almost_full(almost_full), .data_count(data_count), .overflow(overflow)
    );

    always #5 PCLK = ~PCLK;

    // Reference model: a plain queue of stored words plus the last popped word and the sticky flag.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout;
    logic          m_ovf;

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            m_q.delete();
            m_dout = '0;
            m_ovf  = 1'b0;
        end else begin
            bit was_full, was_empty;
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            if (rd_en && !was_empty) m_dout = m_q.pop_front();
            if (wr_en && !was_full)  m_q.push_back(din);
            if (wr_en && was_full)   m_ovf = 1'b1;
            else if (ovf_clr)        m_ovf = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge PCLK) begin
        if (run_cmp) begin
            chk("m_dout",  32'(dout),        32'(m_dout));
            chk("m_count", 32'(data_count),  32'(m_q.size()));
            chk("m_full",  32'(full),        32'(m_q.size() == DEPTH));
            chk("m_empty", 32'(empty),       32'(m_q.size() == 0));
            chk("m_af",    32'(almost_full), 32'(m_q.size() >= AFL));
            chk("m_ovf",   32'(overflow),    32'(m_ovf));
        end
    end

    // Drive inputs for one edge, then return at a quiet point after the following negedge.
    task automatic tick(input logic w, input logic [DW-1:0] d, input logic r, input logic c);
        wr_en = w; din = d; rd_en = r; ovf_clr = c;
        @(posedge PCLK);
        @(negedge PCLK);
        #2;
    endtask

    initial begin
        PRESET = 1'b1; wr_en = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0; din = '0;
        repeat (2) @(negedge PCLK);
        #2;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(data_count), 32'd0);
        chk("rst_dout",  32'(dout), 32'd0);
        PRESET = 1'b0;
        run_cmp = 1'b1;
        tick(0, 16'h0, 0, 0);

        // Fill to full
        for (int i = 0; i < DEPTH; i++) begin
            tick(1, DW'(i), 0, 0);
            chk("fill_count", 32'(data_count), 32'(i + 1));
            chk("fill_af", 32'(almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_empty", 32'(empty), 32'd0);

        // Overflow on a full FIFO
        tick(1, 16'hBEEF, 0, 0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(data_count), 32'd16);

        for (int i = 0; i < DEPTH; i++) begin
            tick(0, 16'h0, 1, 0);
            chk("drain_dout", 32'(dout), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        tick(0, 16'h0, 0, 1);
        chk("ovf_clr", 32'(overflow), 32'd0);

        // Steady state at occupancy 5; pointers wrap
        for (int i = 0; i < 5; i++) tick(1, DW'(16'h100 + i), 0, 0);
        for (int i = 0; i < 40; i++) begin
            tick(1, DW'(16'h200 + i), 1, 0);
            chk("ss_count", 32'(data_count), 32'd5);
            chk("ss_dout", 32'(dout), (i < 5) ? 32'(16'h100 + i) : 32'(16'h200 + i - 5));
        end
        for (int i = 0; i < 5; i++) begin
            tick(0, 16'h0, 1, 0);
            chk("ss_tail", 32'(dout), 32'(16'h223 + i));
        end

        // Push and pop together while empty
        tick(1, 16'h00A5, 1, 0);
        chk("emp_count", 32'(data_count), 32'd1);
        chk("emp_dout", 32'(dout), 32'h0227);
        tick(0, 16'h0, 1, 0);
        chk("emp_pop", 32'(dout), 32'h00A5);
        chk("emp_empty", 32'(empty), 32'd1);

        // Push and pop together while full
        for (int i = 0; i < DEPTH; i++) tick(1, DW'(16'h300 + i), 0, 0);
        tick(1, 16'hDEAD, 1, 0);
        chk("full_count", 32'(data_count), 32'd15);
        chk("full_ovf", 32'(overflow), 32'd1);
        chk("full_dout", 32'(dout), 32'h0300);
        chk("full_full", 32'(full), 32'd0);

        // Reset mid-stream with overflow still set and wr_en high
        for (int i = 0; i < 15; i++) tick(0, 16'h0, 1, 0);
        tick(1, 16'h0111, 0, 0);
        tick(1, 16'h0222, 0, 0);
        tick(1, 16'h0333, 0, 0);
        tick(0, 16'h0, 1, 0);
        chk("pre_rst_dout", 32'(dout), 32'h0111);
        tick(1, 16'h0444, 0, 0);
        chk("pre_rst_count", 32'(data_count), 32'd3);
        PRESET = 1'b1;
        #1;
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_full",  32'(full), 32'd0);
        chk("arst_count", 32'(data_count), 32'd0);
        chk("arst_ovf",   32'(overflow), 32'd0);
        chk("arst_dout",  32'(dout), 32'd0);
        chk("arst_af",    32'(almost_full), 32'd0);
        @(posedge PCLK);
        @(negedge PCLK);
        #2;
        chk("arst_hold", 32'(data_count), 32'd0);
        PRESET = 1'b0;
        tick(1, 16'h0555, 0, 0);
        tick(0, 16'h0, 1, 0);
        chk("post_rst_dout", 32'(dout), 32'h0555);
        chk("post_rst_empty", 32'(empty), 32'd1);
        tick(0, 16'h0, 0, 0);

        run_cmp = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
